// File: rtl/uart_frame_parser.sv
// UART command-frame parser: delineates HEADER/CMD/LEN/payload/CSUM frames from
// the receiver byte stream, holds the payload until the checksum verifies, then
// replays good frames on a valid/ready stream. Bad, oversized or stalled frames
// are dropped and flagged with one-cycle pulses.
module uart_frame_parser #(
    parameter int         DATA_WIDTH     = 8,
    parameter logic [7:0] HEADER         = 8'hA5,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 27000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_vld_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_last_o,
    input  logic                  out_ready_i,
    output logic [7:0]            cmd_o,
    output logic [7:0]            len_o,
    output logic                  frame_ok_o,
    output logic                  err_o,
    output logic                  drop_o
);

    localparam int         IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int         TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {HUNT, CMD, LEN, PAYLOAD, CSUM, REPLAY} state_t;

    state_t          state_q, state_d;
    logic            vld_d;
    logic            byte_ev;
    logic [7:0]      cmd_r, len_r, csum_acc;
    logic [IW-1:0]   idx, rd_idx;
    logic [TW-1:0]   tmo_cnt;
    logic            in_frame, tmo_hit, hs, rd_last, wr_last;
    logic            ok_d, err_d, drop_d;
    logic [DATA_WIDTH-1:0] pl_buf [MAX_LEN];

    // A held strobe counts once: only the low-to-high transition is a byte.
    assign byte_ev  = data_vld_i && !vld_d;
    assign in_frame = (state_q == CMD) || (state_q == LEN) ||
                      (state_q == PAYLOAD) || (state_q == CSUM);
    // A byte arriving on the terminal-count cycle keeps the frame alive.
    assign tmo_hit  = in_frame && !byte_ev && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign hs       = out_valid_o && out_ready_i;
    assign rd_last  = (8'(rd_idx) == len_r - 8'd1);
    assign wr_last  = (8'(idx) == len_r - 8'd1);

    // Stream outputs come straight from state so reset drops them asynchronously.
    assign out_valid_o = (state_q == REPLAY);
    assign out_data_o  = out_valid_o ? pl_buf[rd_idx] : '0;
    assign out_last_o  = out_valid_o && rd_last;
    assign cmd_o       = cmd_r;
    assign len_o       = len_r;

    // Next-state and status-pulse decode.
    always_comb begin
        state_d = state_q;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        drop_d  = 1'b0;
        case (state_q)
            HUNT:    if (byte_ev && data_i == HEADER) state_d = CMD;
            CMD:     if (byte_ev) state_d = LEN;
            LEN: if (byte_ev) begin
                if (data_i > MAX_LEN_B) begin
                    err_d   = 1'b1;
                    state_d = HUNT;
                end else if (data_i == 8'd0) begin
                    state_d = CSUM;
                end else begin
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: if (byte_ev && wr_last) state_d = CSUM;
            CSUM: if (byte_ev) begin
                if (data_i == csum_acc) begin
                    ok_d    = 1'b1;
                    state_d = (len_r != 8'd0) ? REPLAY : HUNT;
                end else begin
                    err_d   = 1'b1;
                    state_d = HUNT;
                end
            end
            REPLAY: begin
                drop_d = byte_ev;
                if (hs && rd_last) state_d = HUNT;
            end
            default: state_d = HUNT;
        endcase
        if (tmo_hit) begin
            err_d   = 1'b1;
            state_d = HUNT;
        end
    end

    // State, frame fields, checksum, indices, timeout counter and pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= HUNT;
            vld_d      <= 1'b1;
            cmd_r      <= '0;
            len_r      <= '0;
            csum_acc   <= '0;
            idx        <= '0;
            rd_idx     <= '0;
            tmo_cnt    <= '0;
            frame_ok_o <= 1'b0;
            err_o      <= 1'b0;
            drop_o     <= 1'b0;
        end else begin
            state_q    <= state_d;
            vld_d      <= data_vld_i;
            frame_ok_o <= ok_d;
            err_o      <= err_d;
            drop_o     <= drop_d;
            if (in_frame && !byte_ev) tmo_cnt <= tmo_cnt + TW'(1);
            else                      tmo_cnt <= '0;
            if (byte_ev) begin
                case (state_q)
                    HUNT: csum_acc <= '0;
                    CMD: begin
                        cmd_r    <= data_i;
                        csum_acc <= csum_acc + data_i;
                    end
                    LEN: if (data_i <= MAX_LEN_B) begin
                        len_r    <= data_i;
                        csum_acc <= csum_acc + data_i;
                        idx      <= '0;
                    end
                    PAYLOAD: begin
                        csum_acc <= csum_acc + data_i;
                        idx      <= idx + IW'(1);
                    end
                    default: ;
                endcase
            end
            if (state_q == CSUM && state_d == REPLAY) rd_idx <= '0;
            else if (hs && !rd_last)                  rd_idx <= rd_idx + IW'(1);
        end
    end

    // Payload buffer; contents need no reset.
    always_ff @(posedge clk) begin
        if (byte_ev && state_q == PAYLOAD) pl_buf[idx] <= data_i;
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser (MAX_LEN=16, TIMEOUT_CYCLES=100).
module tb_uart_frame_parser;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       data_vld_i = 1'b0;
    logic [7:0] data_i = 8'h00;
    logic       out_valid_o, out_last_o, out_ready_i;
    logic [7:0] out_data_o, cmd_o, len_o;
    logic       frame_ok_o, err_o, drop_o;

    uart_frame_parser #(.DATA_WIDTH(8), .HEADER(8'hA5), .MAX_LEN(16), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst(rst), .data_vld_i(data_vld_i), .data_i(data_i),
        .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_last_o(out_last_o),
        .out_ready_i(out_ready_i), .cmd_o(cmd_o), .len_o(len_o),
        .frame_ok_o(frame_ok_o), .err_o(err_o), .drop_o(drop_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0, ev_cyc = 0, err_cyc = 0;
    int ok_cnt = 0, err_cnt = 0, drop_cnt = 0;
    logic       vld_prev = 1'b0;
    logic [7:0] rx_q[$];
    logic       rx_last_q[$];
    logic [7:0] rx_cmd, rx_len;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic [7:0] tx[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Cycle counter and the cycle of the latest strobe rising edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (data_vld_i && !vld_prev) ev_cyc = cyc;
        vld_prev = data_vld_i;
    end

    // Output monitor: pulse counts, handshaken bytes, stall stability.
    always @(negedge clk) begin
        if (rst) begin
            if (frame_ok_o) ok_cnt++;
            if (err_o) begin err_cnt++; err_cyc = cyc; end
            if (drop_o) drop_cnt++;
            if (frame_ok_o || err_o || drop_o)
                chk("pulse_excl", 32'(frame_ok_o) + 32'(err_o) + 32'(drop_o), 1);
            if (prev_stall && out_valid_o) chk("stall_hold", out_data_o, prev_data);
            if (out_valid_o && out_ready_i) begin
                if (rx_q.size() == 0) begin rx_cmd = cmd_o; rx_len = len_o; end
                rx_q.push_back(out_data_o);
                rx_last_q.push_back(out_last_o);
            end
            prev_stall = out_valid_o && !out_ready_i;
            prev_data  = out_data_o;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clr();
        ok_cnt = 0; err_cnt = 0; drop_cnt = 0;
        rx_q.delete(); rx_last_q.delete();
    endtask

    task automatic send_tx(input int hold = 1);
        foreach (tx[i]) begin
            data_i = tx[i]; data_vld_i = 1'b1;
            tick(hold);
            data_vld_i = 1'b0;
            tick();
        end
    endtask

    task automatic chk_stream(input string tag, input int n, input logic [7:0] base);
        chk({tag, "_cnt"}, rx_q.size(), n);
        for (int i = 0; i < n && i < rx_q.size(); i++) begin
            chk({tag, "_data"}, rx_q[i], base + 8'(i));
            chk({tag, "_last"}, rx_last_q[i], (i == n - 1));
        end
    endtask

    initial begin
        out_ready_i = 1'b1;
        tick(3);
        chk("reset_outs", {out_valid_o, out_last_o, frame_ok_o, err_o, drop_o, out_data_o, cmd_o, len_o}, 0);
        rst = 1'b1;
        tick(2);

        // Good frame, no backpressure.
        clr(); tx = '{8'hA5, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h19}; send_tx(); tick(8);
        chk("good_ok", ok_cnt, 1); chk("good_err", err_cnt, 0);
        chk_stream("good", 3, 8'h01);
        chk("good_cmd", rx_cmd, 8'h10); chk("good_len", rx_len, 8'h03);

        // Bad checksum, then the good frame again.
        clr(); tx = '{8'hA5, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h18}; send_tx(); tick(8);
        chk("badcs_err", err_cnt, 1); chk("badcs_ok", ok_cnt, 0); chk("badcs_novalid", rx_q.size(), 0);
        clr(); tx = '{8'hA5, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h19}; send_tx(); tick(8);
        chk("recover_ok", ok_cnt, 1); chk_stream("recover", 3, 8'h01);

        // Garbage then zero-length frame.
        clr(); tx = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h20, 8'h00, 8'h20}; send_tx(); tick(6);
        chk("len0_ok", ok_cnt, 1); chk("len0_err", err_cnt, 0); chk("len0_novalid", rx_q.size(), 0);
        chk("len0_cmd", cmd_o, 8'h20); chk("len0_len", len_o, 8'h00);

        // Oversized length.
        clr(); tx = '{8'hA5, 8'h01, 8'h11}; send_tx(); tick(4);
        chk("len17_err", err_cnt, 1); chk("len17_ok", ok_cnt, 0);

        // Stall after two payload bytes: timeout exactly 100 cycles after last byte.
        clr(); tx = '{8'hA5, 8'h01, 8'h03, 8'hAA, 8'hBB}; send_tx(); tick(120);
        chk("tmo_err", err_cnt, 1); chk("tmo_delay", err_cyc - ev_cyc, 100);

        // 16-byte frame with ready toggling every 3 cycles and a byte injected mid-replay.
        clr();
        tx = '{8'hA5, 8'h30, 8'h10};
        for (int i = 0; i < 16; i++) tx.push_back(8'(i));
        tx.push_back(8'hB8);
        send_tx();
        for (int i = 0; i < 80; i++) begin
            out_ready_i = ((i / 3) % 2) == 1;
            if (i == 7)      begin data_i = 8'hA5; data_vld_i = 1'b1; end
            else if (i == 8) data_vld_i = 1'b0;
            tick();
        end
        out_ready_i = 1'b1; tick(4);
        chk("bp_ok", ok_cnt, 1); chk("bp_drop", drop_cnt, 1); chk("bp_err", err_cnt, 0);
        chk_stream("bp", 16, 8'h00);
        chk("bp_cmd", rx_cmd, 8'h30); chk("bp_len", rx_len, 8'h10);

        // Strobe held 5 cycles per byte counts once.
        clr(); tx = '{8'hA5, 8'h40, 8'h01, 8'h05, 8'h46}; send_tx(5); tick(6);
        chk("hold_ok", ok_cnt, 1); chk("hold_err", err_cnt, 0); chk_stream("hold", 1, 8'h05);

        // Reset mid-payload clears outputs asynchronously.
        clr(); tx = '{8'hA5, 8'h50, 8'h04, 8'h01, 8'h02}; send_tx();
        #2 rst = 1'b0; #1;
        chk("rst_pl_outs", {out_valid_o, frame_ok_o, err_o, drop_o, cmd_o, len_o}, 0);
        tick(2); rst = 1'b1; tick(2);

        // Reset mid-replay drops out_valid_o without a clock edge.
        out_ready_i = 1'b0;
        clr(); tx = '{8'hA5, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h19}; send_tx(); tick(2);
        chk("rst_rp_pre", out_valid_o, 1);
        #2 rst = 1'b0; #1;
        chk("rst_rp_valid", out_valid_o, 0);
        tick(2); rst = 1'b1; out_ready_i = 1'b1; tick(2);

        // Full frame after reset.
        clr(); tx = '{8'hA5, 8'h60, 8'h02, 8'h0A, 8'h0B, 8'h77}; send_tx(); tick(6);
        chk("post_rst_ok", ok_cnt, 1); chk_stream("post_rst", 2, 8'h0A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
